// File: rtl/dilithium_pkg.sv
// Shared Dilithium sizing constants, packer state encoding and the pk length helper.
package dilithium_pkg;

    localparam int N                  = 256;
    localparam int SEEDBYTES          = 32;
    localparam int POLYT1_PACKEDBYTES = 320;

    typedef enum logic [1:0] {
        PK_IDLE = 2'd0,
        PK_RHO  = 2'd1,
        PK_T1   = 2'd2
    } pk_state_e;

    function automatic int pk_bytes(input int k);
        return SEEDBYTES + POLYT1_PACKEDBYTES * k;
    endfunction

endpackage

// File: rtl/bit_accum_10to8.sv
// Little-endian bit accumulator: takes 10-bit coefficients in, hands 8-bit bytes out.
// The next-state values are exported so the parent can register its outputs from them.
module bit_accum_10to8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        accept,
    input  logic        emit,
    input  logic [9:0]  coef,
    output logic [16:0] acc_nxt,
    output logic [4:0]  nb_nxt
);

    logic [16:0] acc;
    logic [4:0]  nb;

    // accept and emit are never both asserted by the parent; accept wins if they were
    always_comb begin
        acc_nxt = acc;
        nb_nxt  = nb;
        if (clr) begin
            acc_nxt = '0;
            nb_nxt  = '0;
        end else if (accept) begin
            acc_nxt = acc | ({7'd0, coef} << nb);
            nb_nxt  = nb + 5'd10;
        end else if (emit) begin
            acc_nxt = acc >> 8;
            nb_nxt  = nb - 5'd8;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            nb  <= '0;
        end else begin
            acc <= acc_nxt;
            nb  <= nb_nxt;
        end
    end

endmodule

// File: rtl/pack_pk_stream.sv
// Streams pk = rho || polyt1_pack(t1[0..K-1]) one byte per handshake from one coefficient per handshake.
// Every output is a flop loaded from the next-state values, so no input reaches an output combinationally.
module pack_pk_stream
    import dilithium_pkg::*;
#(
    parameter int K = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] rho_in,
    input  logic         coef_valid,
    output logic         coef_ready,
    input  logic [31:0]  coef_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_byte,
    output logic         out_last,
    output logic         busy,
    output logic         done,
    output logic         coef_err
);

    localparam int PK_BYTES = pk_bytes(K);
    localparam int N_COEF   = N * K;
    localparam int BC_W     = $clog2(PK_BYTES);
    localparam int CC_W     = $clog2(N_COEF + 1);

    localparam logic [BC_W-1:0] LAST_RHO   = BC_W'(SEEDBYTES - 1);
    localparam logic [BC_W-1:0] LAST_BYTE  = BC_W'(PK_BYTES - 1);
    localparam logic [CC_W-1:0] COEF_TOTAL = CC_W'(N_COEF);

    if (!(K == 4 || K == 6 || K == 8)) begin : g_bad_k
        $error("pack_pk_stream: K must be 4, 6 or 8");
    end

    pk_state_e         state, state_n;
    logic [BC_W-1:0]   byte_cnt, byte_cnt_n;
    logic [CC_W-1:0]   coef_cnt, coef_cnt_n;
    logic [255:0]      rho_q, rho_n;
    logic              err_n, done_n, busy_n;
    logic              out_valid_n, out_last_n, coef_ready_n;
    logic [7:0]        out_byte_n;
    logic              acc_clr, acc_accept, acc_emit;
    logic [16:0]       acc_nxt;
    logic [4:0]        nb_nxt;
    logic              out_hs, coef_hs;

    assign out_hs  = out_valid & out_ready;
    assign coef_hs = coef_valid & coef_ready;

    bit_accum_10to8 u_accum (
        .clk     (clk),
        .rst     (rst),
        .clr     (acc_clr),
        .accept  (acc_accept),
        .emit    (acc_emit),
        .coef    (coef_in[9:0]),
        .acc_nxt (acc_nxt),
        .nb_nxt  (nb_nxt)
    );

    always_comb begin
        state_n    = state;
        byte_cnt_n = byte_cnt;
        coef_cnt_n = coef_cnt;
        rho_n      = rho_q;
        err_n      = coef_err;
        done_n     = 1'b0;
        acc_clr    = 1'b0;
        acc_accept = 1'b0;
        acc_emit   = 1'b0;

        unique case (state)
            PK_IDLE: begin
                if (start) begin
                    state_n    = PK_RHO;
                    byte_cnt_n = '0;
                    coef_cnt_n = '0;
                    rho_n      = rho_in;
                    err_n      = 1'b0;
                    acc_clr    = 1'b1;
                end
            end
            PK_RHO: begin
                if (out_hs) begin
                    byte_cnt_n = byte_cnt + 1'b1;
                    if (byte_cnt == LAST_RHO) state_n = PK_T1;
                end
            end
            PK_T1: begin
                // ready needs nb < 8 and valid needs nb >= 8, so at most one of these fires
                if (coef_hs) begin
                    acc_accept = 1'b1;
                    coef_cnt_n = coef_cnt + 1'b1;
                    if (|coef_in[31:10]) err_n = 1'b1;
                end
                if (out_hs) begin
                    acc_emit   = 1'b1;
                    byte_cnt_n = byte_cnt + 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        state_n = PK_IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = PK_IDLE;
        endcase

        busy_n       = (state_n != PK_IDLE);
        out_valid_n  = (state_n == PK_RHO) || ((state_n == PK_T1) && (nb_nxt >= 5'd8));
        coef_ready_n = (state_n == PK_T1) && (nb_nxt < 5'd8) && (coef_cnt_n < COEF_TOTAL);
        out_last_n   = (state_n == PK_T1) && (nb_nxt >= 5'd8) && (byte_cnt_n == LAST_BYTE);
        out_byte_n   = 8'd0;
        if (state_n == PK_RHO)
            out_byte_n = rho_n[{byte_cnt_n[4:0], 3'b000} +: 8];
        else if (out_valid_n)
            out_byte_n = acc_nxt[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= PK_IDLE;
            byte_cnt   <= '0;
            coef_cnt   <= '0;
            rho_q      <= '0;
            coef_err   <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_byte   <= 8'd0;
            coef_ready <= 1'b0;
        end else begin
            state      <= state_n;
            byte_cnt   <= byte_cnt_n;
            coef_cnt   <= coef_cnt_n;
            rho_q      <= rho_n;
            coef_err   <= err_n;
            done       <= done_n;
            busy       <= busy_n;
            out_valid  <= out_valid_n;
            out_last   <= out_last_n;
            out_byte   <= out_byte_n;
            coef_ready <= coef_ready_n;
        end
    end

endmodule

// File: tb/tb_pack_pk_stream.sv
// Bench for pack_pk_stream: K=4/6/8 instances driven with directed and random streams,
// checked against a group-of-4 polyt1_pack model of the public key.
module tb_pack_pk_stream;

    localparam logic [255:0] RHO_A =
        256'h449e_3b1c0d6f_5a2e8b4c_9d7f10a2_b3c4d5e6_f708192a_3b4c5d6e_7f8091a2_77e5;

    logic               clk = 1'b0;
    logic               rst;
    logic [2:0]         start_v;
    logic [2:0][255:0]  rho_v;
    logic [2:0]         cv_v;
    logic [2:0]         cr_v;
    logic [2:0][31:0]   ci_v;
    logic [2:0]         ov_v;
    logic [2:0]         or_v;
    logic [2:0][7:0]    ob_v;
    logic [2:0]         last_v;
    logic [2:0]         busy_v;
    logic [2:0]         done_v;
    logic [2:0]         err_v;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] got[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int KG = 4 + 2 * g;
        pack_pk_stream #(.K(KG)) dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start_v[g]),
            .rho_in     (rho_v[g]),
            .coef_valid (cv_v[g]),
            .coef_ready (cr_v[g]),
            .coef_in    (ci_v[g]),
            .out_valid  (ov_v[g]),
            .out_ready  (or_v[g]),
            .out_byte   (ob_v[g]),
            .out_last   (last_v[g]),
            .busy       (busy_v[g]),
            .done       (done_v[g]),
            .coef_err   (err_v[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_quiet(input int idx, input string tag);
        chk({tag, "_ready"}, 32'(cr_v[idx]), 32'd0);
        chk({tag, "_valid"}, 32'(ov_v[idx]), 32'd0);
        chk({tag, "_byte"},  32'(ob_v[idx]), 32'd0);
        chk({tag, "_last"},  32'(last_v[idx]), 32'd0);
        chk({tag, "_busy"},  32'(busy_v[idx]), 32'd0);
        chk({tag, "_done"},  32'(done_v[idx]), 32'd0);
        chk({tag, "_err"},   32'(err_v[idx]), 32'd0);
    endtask

    // mode 0: all zero, 1: directed head, 2: random 10-bit, 3: random with out-of-range words
    task automatic run_stream(input int idx, input logic [255:0] rho, input int mode,
                              input int gap_pct, input int stall_pct, input int abort_at,
                              input bit poke_start);
        int          k      = 4 + 2 * idx;
        int          total  = 256 * k;
        int          pk     = 32 + 320 * k;
        int          budget = 12 * pk + 200;
        int unsigned coefs[$];
        logic [7:0]  expb[$];
        bit          exp_err = 1'b0;
        int          bi = 0, ci = 0, cyc = 0;
        bit          held = 1'b0;
        logic [7:0]  hb;
        logic        hl;
        int unsigned c;

        for (int i = 0; i < total; i++) begin
            case (mode)
                0:       c = 0;
                1:       c = (i < 4) ? i + 1 : (i < 8) ? 32'h3ff : 0;
                2:       c = $urandom_range(1023);
                default: c = (i == 5) ? 32'h400 : (i == 700) ? 32'hdead0155 : $urandom_range(1023);
            endcase
            coefs.push_back(c);
            if ((c >> 10) != 0) exp_err = 1'b1;
        end
        for (int i = 0; i < 32; i++) expb.push_back(rho[8*i +: 8]);
        for (int g = 0; g < total / 4; g++) begin
            int unsigned c0 = coefs[4*g] & 1023;
            int unsigned c1 = coefs[4*g+1] & 1023;
            int unsigned c2 = coefs[4*g+2] & 1023;
            int unsigned c3 = coefs[4*g+3] & 1023;
            expb.push_back(8'(c0));
            expb.push_back(8'((c0 >> 8) | (c1 << 2)));
            expb.push_back(8'((c1 >> 6) | (c2 << 4)));
            expb.push_back(8'((c2 >> 4) | (c3 << 6)));
            expb.push_back(8'(c3 >> 2));
        end
        got = {};

        @(posedge clk); #1;
        rho_v[idx]   = rho;
        start_v[idx] = 1'b1;
        @(posedge clk); #1;
        start_v[idx] = 1'b0;
        chk("start_busy",  32'(busy_v[idx]), 32'd1);
        chk("start_valid", 32'(ov_v[idx]), 32'd1);
        chk("start_err",   32'(err_v[idx]), 32'd0);

        while (bi < pk && cyc < budget) begin
            if (abort_at >= 0 && bi >= abort_at) begin
                rst = 1'b1;
                #1;
                chk_quiet(idx, "abort");
                or_v[idx] = 1'b0;
                cv_v[idx] = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            start_v[idx] = poke_start && (cyc == 40);
            if (poke_start && cyc == 40) rho_v[idx] = ~rho;
            or_v[idx] = ($urandom_range(99) >= stall_pct);
            if (ci < total && $urandom_range(99) >= gap_pct) begin
                cv_v[idx] = 1'b1;
                ci_v[idx] = coefs[ci];
            end else begin
                cv_v[idx] = 1'b0;
                ci_v[idx] = $urandom;
            end
            if (held) begin
                chk("hold_valid", 32'(ov_v[idx]), 32'd1);
                chk("hold_byte",  32'(ob_v[idx]), 32'(hb));
                chk("hold_last",  32'(last_v[idx]), 32'(hl));
                held = 1'b0;
            end
            chk("excl", 32'(ov_v[idx] & cr_v[idx]), 32'd0);
            if (ci >= total) chk("ready_over", 32'(cr_v[idx]), 32'd0);
            if (ov_v[idx] && or_v[idx]) begin
                chk("byte", 32'(ob_v[idx]), 32'(expb[bi]));
                chk("last", 32'(last_v[idx]), 32'(bi == pk - 1));
                got.push_back(ob_v[idx]);
                bi++;
            end else if (ov_v[idx]) begin
                held = 1'b1;
                hb   = ob_v[idx];
                hl   = last_v[idx];
            end
            if (cv_v[idx] && cr_v[idx]) ci++;
            @(posedge clk); #1;
            cyc++;
        end
        start_v[idx] = 1'b0;
        or_v[idx]    = 1'b0;
        cv_v[idx]    = 1'b0;
        chk("byte_count", bi, pk);
        chk("coef_count", ci, total);
        chk("end_done",   32'(done_v[idx]), 32'd1);
        chk("end_busy",   32'(busy_v[idx]), 32'd0);
        chk("end_valid",  32'(ov_v[idx]), 32'd0);
        chk("end_ready",  32'(cr_v[idx]), 32'd0);
        chk("end_err",    32'(err_v[idx]), 32'(exp_err));
        @(posedge clk); #1;
        chk("done_pulse", 32'(done_v[idx]), 32'd0);
    endtask

    initial begin
        logic [7:0] dir_exp [10];
        dir_exp = '{8'h01, 8'h08, 8'h30, 8'h00, 8'h01, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff};
        rst     = 1'b1;
        start_v = '0;
        rho_v   = '0;
        cv_v    = '0;
        ci_v    = '0;
        or_v    = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk_quiet(i, "reset");
        rst = 1'b0;

        // K=6 all-zero coefficients with the reference seed
        run_stream(1, RHO_A, 0, 0, 0, -1, 1'b0);
        chk("rho_byte0", 32'(got[0]), 32'h0e5);
        chk("rho_byte31", 32'(got[31]), 32'h044);
        chk("zero_len", got.size(), 1952);

        // directed packing groups: 1,2,3,4 then 0x3FF x4
        run_stream(1, RHO_A, 1, 0, 0, -1, 1'b0);
        for (int i = 0; i < 10; i++) chk("directed", 32'(got[32+i]), 32'(dir_exp[i]));

        // random t1 with coefficient gaps and sink stalls, all three sizes
        run_stream(1, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                   2, 20, 20, -1, 1'b0);
        run_stream(0, ~RHO_A, 2, 20, 20, -1, 1'b0);
        chk("k4_len", got.size(), 1312);
        run_stream(2, RHO_A, 2, 20, 20, -1, 1'b0);
        chk("k8_len", got.size(), 2592);

        // out-of-range coefficient words raise a sticky error
        run_stream(1, RHO_A, 3, 0, 0, -1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("err_sticky", 32'(err_v[1]), 32'd1);

        // abort mid-T1, then a full stream with a start poked while busy
        run_stream(1, RHO_A, 2, 10, 10, 200, 1'b0);
        run_stream(1, ~RHO_A, 2, 10, 10, -1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
